// File: rtl/csi_pkg.sv
// -----------------------------------------------------------------------------
// csi_pkg
// Shared constants and types for the CSI subcarrier sequencer.
//   W          : signed width of magnitude/phase samples
//   N_SC       : subcarriers per CSI frame
//   IDX_W      : subcarrier index width (holds N_SC-1)
//   PH_JUMP_TH : antenna-2 phase-jump threshold (signed, strict >)
//   CNT_W      : width of the saturating jump counter
// -----------------------------------------------------------------------------
package csi_pkg;

    localparam int W          = 20;
    localparam int N_SC       = 30;
    localparam int IDX_W      = 5;
    localparam int PH_JUMP_TH = 29;
    localparam int CNT_W      = 8;

    typedef struct packed {
        logic signed [W-1:0] m1;
        logic signed [W-1:0] m2;
        logic signed [W-1:0] m3;
        logic signed [W-1:0] p1;
        logic signed [W-1:0] p2;
        logic signed [W-1:0] p3;
    } csi_sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Subcarrier index successor with wrap at the end of a frame.
    function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] res;
        if (idx == IDX_W'(N_SC - 1)) begin
            res = {IDX_W{1'b0}};
        end else begin
            res = idx + IDX_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/csi_phase_jump_det.sv
// -----------------------------------------------------------------------------
// csi_phase_jump_det
// Combinational antenna-2 phase-jump detector.
//   prev_p2_i : phase of the previously accepted sample
//   p2_i      : phase of the sample being accepted
//   first_i   : 1 = first sample of a frame, never flagged
//   jump_o    : (prev_p2 - p2) > PH_JUMP_TH, evaluated at W+1 bits
// -----------------------------------------------------------------------------
module csi_phase_jump_det
    import csi_pkg::*;
(
    input  logic signed [W-1:0] prev_p2_i,
    input  logic signed [W-1:0] p2_i,
    input  logic                first_i,
    output logic                jump_o
);

    localparam logic signed [W:0] TH_EXT = (W+1)'(PH_JUMP_TH);

    logic signed [W:0] diff_s;

    // One extra bit so that full-scale phase wraps cannot overflow the difference.
    always_comb begin
        diff_s = {prev_p2_i[W-1], prev_p2_i} - {p2_i[W-1], p2_i};
        jump_o = (!first_i) && (diff_s > TH_EXT);
    end

endmodule

// File: rtl/csi_subcarrier_sequencer.sv
// -----------------------------------------------------------------------------
// csi_subcarrier_sequencer
// Latches per-subcarrier CSI samples, tags them with a subcarrier index,
// flags antenna-2 phase jumps (holding the index on a jump) and hands them
// downstream over a valid/ready handshake.
//   clk, rst                 : clock, asynchronous active-high reset
//   csi_valid, m1..m3, p1..p3: incoming sample strobe and data
//   out_ready                : downstream accepts the pending output
//   clr                      : synchronous clear of overflow/jump_cnt/index/frame
//   out_valid, *_out, sc_idx : pending output sample and its index
//   jump_flag                : pending sample had a phase jump
//   frame_done               : pulse after the last subcarrier is handed off
//   overflow                 : sticky, a sample was dropped
//   jump_cnt                 : saturating count of detected jumps
// -----------------------------------------------------------------------------
module csi_subcarrier_sequencer
    import csi_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                csi_valid,
    input  logic signed [W-1:0] m1,
    input  logic signed [W-1:0] m2,
    input  logic signed [W-1:0] m3,
    input  logic signed [W-1:0] p1,
    input  logic signed [W-1:0] p2,
    input  logic signed [W-1:0] p3,
    input  logic                out_ready,
    input  logic                clr,
    output logic                out_valid,
    output logic signed [W-1:0] m1_out,
    output logic signed [W-1:0] m2_out,
    output logic signed [W-1:0] m3_out,
    output logic signed [W-1:0] p1_out,
    output logic signed [W-1:0] p2_out,
    output logic signed [W-1:0] p3_out,
    output logic [IDX_W-1:0]    sc_idx,
    output logic                jump_flag,
    output logic                frame_done,
    output logic                overflow,
    output logic [CNT_W-1:0]    jump_cnt
);

    state_t              state_q,      state_d;
    csi_sample_t         sample_q,     sample_d;
    logic [IDX_W-1:0]    sc_idx_q,     sc_idx_d;
    logic                jump_flag_q,  jump_flag_d;
    logic                frame_done_q, frame_done_d;
    logic                overflow_q,   overflow_d;
    logic [CNT_W-1:0]    jump_cnt_q,   jump_cnt_d;
    logic [IDX_W-1:0]    idx_q,        idx_d;
    logic signed [W-1:0] prev_p2_q,    prev_p2_d;
    logic                first_q,      first_d;

    logic                handshake_s;
    logic                accept_s;
    logic                drop_s;
    logic                frame_end_s;
    logic [IDX_W-1:0]    idx_adv_s;
    logic                first_eff_s;
    logic signed [W-1:0] prev_eff_s;
    logic                jump_s;

    assign handshake_s = (state_q == BUSY) && out_ready;
    assign accept_s    = csi_valid && ((state_q == IDLE) || out_ready);
    assign drop_s      = csi_valid && (state_q == BUSY) && !out_ready;
    assign frame_end_s = handshake_s && !jump_flag_q && (sc_idx_q == IDX_W'(N_SC - 1));
    // A back-to-back sample sees the index already advanced by this handshake.
    assign idx_adv_s   = (handshake_s && !jump_flag_q) ? idx_next(idx_q) : idx_q;
    // clr or a frame boundary in the same cycle makes the new sample a frame start.
    assign first_eff_s = clr || frame_end_s || first_q;
    assign prev_eff_s  = clr ? {W{1'b0}} : prev_p2_q;

    csi_phase_jump_det u_jump_det (
        .prev_p2_i (prev_eff_s),
        .p2_i      (p2),
        .first_i   (first_eff_s),
        .jump_o    (jump_s)
    );

    // Next-state, datapath and counter update logic.
    always_comb begin
        state_d      = state_q;
        sample_d     = sample_q;
        sc_idx_d     = sc_idx_q;
        jump_flag_d  = jump_flag_q;
        frame_done_d = frame_end_s;
        overflow_d   = overflow_q;
        jump_cnt_d   = jump_cnt_q;
        idx_d        = idx_q;
        prev_p2_d    = prev_p2_q;
        first_d      = first_q;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (out_ready && !csi_valid) begin
                    state_d = IDLE;
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clr) begin
            idx_d = {IDX_W{1'b0}};
        end else begin
            idx_d = idx_adv_s;
        end

        if (accept_s) begin
            sample_d.m1 = m1;
            sample_d.m2 = m2;
            sample_d.m3 = m3;
            sample_d.p1 = p1;
            sample_d.p2 = p2;
            sample_d.p3 = p3;
            sc_idx_d    = idx_d;
            jump_flag_d = jump_s;
            prev_p2_d   = p2;
            first_d     = 1'b0;
        end else begin
            if (clr) begin
                prev_p2_d = {W{1'b0}};
            end else begin
                prev_p2_d = prev_p2_q;
            end
            if (clr || frame_end_s) begin
                first_d = 1'b1;
            end else begin
                first_d = first_q;
            end
        end

        if (clr) begin
            overflow_d = 1'b0;
        end else if (drop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end

        if (clr) begin
            jump_cnt_d = {CNT_W{1'b0}};
        end else if (accept_s && jump_s && (jump_cnt_q != {CNT_W{1'b1}})) begin
            jump_cnt_d = jump_cnt_q + CNT_W'(1);
        end else begin
            jump_cnt_d = jump_cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sample_q     <= '0;
            sc_idx_q     <= {IDX_W{1'b0}};
            jump_flag_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            jump_cnt_q   <= {CNT_W{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            prev_p2_q    <= {W{1'b0}};
            first_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            sample_q     <= sample_d;
            sc_idx_q     <= sc_idx_d;
            jump_flag_q  <= jump_flag_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            jump_cnt_q   <= jump_cnt_d;
            idx_q        <= idx_d;
            prev_p2_q    <= prev_p2_d;
            first_q      <= first_d;
        end
    end

    assign out_valid  = (state_q == BUSY);
    assign m1_out     = sample_q.m1;
    assign m2_out     = sample_q.m2;
    assign m3_out     = sample_q.m3;
    assign p1_out     = sample_q.p1;
    assign p2_out     = sample_q.p2;
    assign p3_out     = sample_q.p3;
    assign sc_idx     = sc_idx_q;
    assign jump_flag  = jump_flag_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign jump_cnt   = jump_cnt_q;

endmodule

// File: tb/tb_csi_subcarrier_sequencer.sv
// -----------------------------------------------------------------------------
// tb_csi_subcarrier_sequencer
// Directed, table-driven self-checking bench for csi_subcarrier_sequencer.
// -----------------------------------------------------------------------------
module tb_csi_subcarrier_sequencer;

    logic               clk;
    logic               rst;
    logic               csi_valid;
    logic signed [19:0] m1, m2, m3, p1, p2, p3;
    logic               out_ready;
    logic               clr;
    logic               out_valid;
    logic signed [19:0] m1_out, m2_out, m3_out, p1_out, p2_out, p3_out;
    logic [4:0]         sc_idx;
    logic               jump_flag;
    logic               frame_done;
    logic               overflow;
    logic [7:0]         jump_cnt;

    int n_pass;
    int n_total;

    csi_subcarrier_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .csi_valid  (csi_valid),
        .m1         (m1),
        .m2         (m2),
        .m3         (m3),
        .p1         (p1),
        .p2         (p2),
        .p3         (p3),
        .out_ready  (out_ready),
        .clr        (clr),
        .out_valid  (out_valid),
        .m1_out     (m1_out),
        .m2_out     (m2_out),
        .m3_out     (m3_out),
        .p1_out     (p1_out),
        .p2_out     (p2_out),
        .p3_out     (p3_out),
        .sc_idx     (sc_idx),
        .jump_flag  (jump_flag),
        .frame_done (frame_done),
        .overflow   (overflow),
        .jump_cnt   (jump_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cv;
        logic        rdy;
        logic        cl;
        logic [19:0] p2v;
        logic [19:0] m1v;
        logic        ev;
        logic [4:0]  esc;
        logic        ejf;
        logic        efd;
        logic        eovf;
        logic [7:0]  ecnt;
        logic [19:0] em1;
        logic [19:0] ep2;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Other channels carry fixed offsets from m1 so one expected value covers all.
    task automatic drive(input logic cv, input logic rdy, input logic cl,
                         input logic [19:0] p2v, input logic [19:0] m1v);
        csi_valid = cv;
        out_ready = rdy;
        clr       = cl;
        p2        = p2v;
        m1        = m1v;
        m2        = m1v + 20'd1;
        m3        = m1v + 20'd2;
        p1        = m1v + 20'd3;
        p3        = m1v + 20'd4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lanes(input string nm);
        logic ok;
        ok = (m2_out == m1_out + 20'sd1) && (m3_out == m1_out + 20'sd2) &&
             (p1_out == m1_out + 20'sd3) && (p3_out == m1_out + 20'sd4);
        chk(nm, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        // cv rdy clr p2 m1 | valid sc jf fd ovf cnt m1_out p2_out
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 20'd100,   20'd1,  1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 20'd1,  20'd100};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 20'd0,     20'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 20'd1,  20'd100};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 20'd60,    20'd2,  1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 8'd1, 20'd2,  20'd60};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 20'd0,     20'd0,  1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 8'd1, 20'd2,  20'd60};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 20'd31,    20'd4,  1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'd1, 20'd4,  20'd31};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 20'd0,     20'd0,  1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'd1, 20'd4,  20'd31};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 20'h7FFFF, 20'd6,  1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 8'd1, 20'd6,  20'h7FFFF};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 20'd0,     20'd0,  1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'd1, 20'd6,  20'h7FFFF};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 20'h80000, 20'd8,  1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 8'd2, 20'd8,  20'h80000};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 20'd0,     20'd0,  1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 8'd2, 20'd8,  20'h80000};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 20'h80000, 20'd10, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 8'd2, 20'd10, 20'h80000};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 20'd0,     20'd11, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 8'd2, 20'd10, 20'h80000};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 20'd0,     20'd0,  1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 8'd2, 20'd10, 20'h80000};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 20'd0,     20'd0,  1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 8'd0, 20'd10, 20'h80000};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 20'h80000, 20'd14, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 20'd14, 20'h80000};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 20'd0,     20'd0,  1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 20'd14, 20'h80000};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 20'd0,     20'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 20'd14, 20'h80000};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 20'd500,   20'd17, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 20'd17, 20'd500};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 20'd0,     20'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 20'd17, 20'd500};

        // Reset state
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 20'd0, 20'd0);
        tick();
        tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sc", {27'd0, sc_idx}, 32'd0);
        chk("rst_m1", {12'd0, m1_out}, 32'd0);
        chk("rst_flags", {28'd0, jump_flag, frame_done, overflow, 1'b0}, 32'd0);
        chk("rst_cnt", {24'd0, jump_cnt}, 32'd0);
        rst = 1'b0;
        tick();

        // Full frame, back-to-back, constant phase
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, 1'b1, 1'b0, 20'd100, 20'(1000 + i));
            tick();
            chk("frm_valid", {31'd0, out_valid}, 32'd1);
            chk("frm_sc", {27'd0, sc_idx}, 32'(i));
            chk("frm_jf", {31'd0, jump_flag}, 32'd0);
            chk("frm_fd", {31'd0, frame_done}, 32'd0);
            chk("frm_m1", {12'd0, m1_out}, 32'(1000 + i));
            chk_lanes("frm_lanes");
        end
        drive(1'b0, 1'b1, 1'b0, 20'd0, 20'd0);
        tick();
        chk("frm_release", {31'd0, out_valid}, 32'd0);
        chk("frm_done", {31'd0, frame_done}, 32'd1);
        chk("frm_ovf", {31'd0, overflow}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 20'd0, 20'd0);
        tick();
        chk("frm_done_pulse", {31'd0, frame_done}, 32'd0);

        // Jump, threshold, wrap extremes, drop and clr
        for (int k = 0; k < 19; k++) begin
            drive(tbl[k].cv, tbl[k].rdy, tbl[k].cl, tbl[k].p2v, tbl[k].m1v);
            tick();
            chk($sformatf("v%0d_valid", k), {31'd0, out_valid}, {31'd0, tbl[k].ev});
            chk($sformatf("v%0d_sc", k), {27'd0, sc_idx}, {27'd0, tbl[k].esc});
            chk($sformatf("v%0d_jf", k), {31'd0, jump_flag}, {31'd0, tbl[k].ejf});
            chk($sformatf("v%0d_fd", k), {31'd0, frame_done}, {31'd0, tbl[k].efd});
            chk($sformatf("v%0d_ovf", k), {31'd0, overflow}, {31'd0, tbl[k].eovf});
            chk($sformatf("v%0d_cnt", k), {24'd0, jump_cnt}, {24'd0, tbl[k].ecnt});
            chk($sformatf("v%0d_m1", k), {12'd0, m1_out}, {12'd0, tbl[k].em1});
            chk($sformatf("v%0d_p2", k), {12'd0, p2_out}, {12'd0, tbl[k].ep2});
        end

        // Run to sc_idx 17 then hit rst with an output pending
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 1'b1, (i == 0) ? 1'b1 : 1'b0, 20'd100, 20'(200 + i));
            tick();
            chk("pre_rst_sc", {27'd0, sc_idx}, 32'(i));
        end
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 20'd0, 20'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_sc", {27'd0, sc_idx}, 32'd0);
        chk("arst_m1", {12'd0, m1_out}, 32'd0);
        tick();
        rst = 1'b0;

        // First sample after reset: prev_p2 is 0, so p2=-100 would jump unless skipped
        drive(1'b1, 1'b1, 1'b0, 20'hFFF9C, 20'd50);
        tick();
        chk("post_valid", {31'd0, out_valid}, 32'd1);
        chk("post_sc", {27'd0, sc_idx}, 32'd0);
        chk("post_jf", {31'd0, jump_flag}, 32'd0);
        chk("post_cnt", {24'd0, jump_cnt}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 20'd0, 20'd0);
        tick();
        chk("post_fd", {31'd0, frame_done}, 32'd0);
        chk("post_release", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
